// File: rtl/uart_arb_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter.
//   arb_state_t : arbiter FSM states (idle, owned by requester 0, owned by requester 1)
//   NEWLINE     : byte value that terminates a line and releases the grant
//   IDLE_CNT_W  : width of the grant idle counter
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } arb_state_t;

  localparam logic [7:0] NEWLINE    = 8'h0A;
  localparam int         IDLE_CNT_W = 8;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO for one requester of the UART arbiter.
//   clk, rst     : clock, asynchronous active-high reset (pointers/count only)
//   push_i       : write push_data_i this cycle (ignored when full)
//   push_data_i  : byte to store
//   pop_i        : advance the read pointer this cycle (ignored when empty)
//   head_o       : oldest stored byte, valid while empty_o is low
//   full_o       : DEPTH bytes stored, from the registered count
//   empty_o      : no bytes stored, from the registered count
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointers are exactly log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; the emptied count makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte streams onto one UART transmitter, one line at a time.
//   CLK, RST               : clock, asynchronous active-high reset
//   reqN_valid/data/ready  : byte offer from requester N into its FIFO
//   wr_valid/wr_data       : registered byte offered to the UART
//   wr_ready               : UART accepts wr_data this cycle
//   grant                  : one-hot owner (bit N = requester N), 00 when idle
// A grant lasts until a newline is loaded or the owner's FIFO stays empty for
// TIMEOUT cycles; ties are broken round-robin.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       wr_valid,
  output logic [7:0] wr_data,
  input  logic       wr_ready,
  output logic [1:0] grant
);

  localparam logic [IDLE_CNT_W-1:0] IDLE_LAST = IDLE_CNT_W'(TIMEOUT - 1);

  arb_state_t            state_q, state_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [IDLE_CNT_W-1:0] idle_q, idle_d;
  logic                  last_q, last_d;   // index of requester served last

  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_data [2];
  logic [1:0] fifo_push;
  logic [1:0] fifo_pop;
  logic [1:0] fifo_full;
  logic [1:0] fifo_empty;
  logic [7:0] fifo_head [2];

  logic       sel;
  logic [7:0] sel_head;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;
  assign req0_ready  = req_ready[0];
  assign req1_ready  = req_ready[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      // Ready comes only from the registered count, and is held low during reset.
      assign req_ready[gi] = !fifo_full[gi] && !RST;
      assign fifo_push[gi] = req_valid[gi] && req_ready[gi];

      uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (CLK),
        .rst         (RST),
        .push_i      (fifo_push[gi]),
        .push_data_i (req_data[gi]),
        .pop_i       (fifo_pop[gi]),
        .head_o      (fifo_head[gi]),
        .full_o      (fifo_full[gi]),
        .empty_o     (fifo_empty[gi])
      );
    end
  endgenerate

  assign sel      = (state_q == ST_GRANT1);
  assign sel_head = fifo_head[sel];

  always_comb begin
    state_d    = state_q;
    wr_valid_d = wr_valid_q;
    wr_data_d  = wr_data_q;
    idle_d     = idle_q;
    last_d     = last_q;
    fifo_pop   = 2'b00;

    // A byte sitting in the output register finishes its handshake in any
    // state; a load below overrides this when the register is refilled.
    if (wr_ready) wr_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        idle_d = '0;
        if (!fifo_empty[0] && !fifo_empty[1]) begin
          state_d = last_q ? ST_GRANT0 : ST_GRANT1;
        end else if (!fifo_empty[0]) begin
          state_d = ST_GRANT0;
        end else if (!fifo_empty[1]) begin
          state_d = ST_GRANT1;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        if (!fifo_empty[sel]) begin
          if (!wr_valid_q || wr_ready) begin
            fifo_pop[sel] = 1'b1;
            wr_valid_d    = 1'b1;
            wr_data_d     = sel_head;
            idle_d        = '0;
            if (sel_head == NEWLINE) begin
              state_d = ST_IDLE;
              last_d  = sel;
            end
          end
        end else if (idle_q == IDLE_LAST) begin
          state_d = ST_IDLE;
          idle_d  = '0;
          last_d  = sel;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idle_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      wr_valid_q <= 1'b0;
      wr_data_q  <= 8'h00;
      idle_q     <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      wr_valid_q <= wr_valid_d;
      wr_data_q  <= wr_data_d;
      idle_q     <= idle_d;
      last_q     <= last_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_data  = wr_data_q;
  assign grant    = {state_q == ST_GRANT1, state_q == ST_GRANT0};

endmodule
